// File: rtl/video_ram_mp.sv
// ============================================================================
// Module  : video_ram_mp
// Brief   : Byte-banked dual-port video RAM with clear engine and hw scroll.
// Revision: 1.0
// ============================================================================
`default_nettype none

module video_ram_mp #(
  parameter int LANES   = 4,
  parameter int WADDR_W = 10,
  parameter int VADDR_W = WADDR_W + $clog2(LANES)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ce,
  input  logic                 we,
  input  logic [VADDR_W-1:0]   addr,
  input  logic [LANES-1:0]     sel,
  input  logic [8*LANES-1:0]   data_i,
  output logic [8*LANES-1:0]   data_o,
  output logic                 cpu_stall,
  input  logic                 clr_start,
  input  logic [7:0]           clr_byte,
  output logic                 clr_busy,
  output logic                 clr_done,
  input  logic                 scroll_we,
  input  logic [VADDR_W-1:0]   scroll_i,
  input  logic                 vsync,
  input  logic [VADDR_W-1:0]   vga_rdaddress,
  output logic [7:0]           vga_q
);

  localparam int LB    = $clog2(LANES);
  localparam int BW    = (LB > 0) ? LB : 1;
  localparam int DEPTH = 1 << WADDR_W;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [WADDR_W:0]     ptr_q, ptr_d;
  logic [7:0]           fill_q, fill_d;
  logic                 w_clr_wr;

  logic [VADDR_W-1:0]   pend_q, pend_d;
  logic [VADDR_W-1:0]   act_q, act_d;
  logic [VADDR_W-1:0]   phys_q;
  logic [VADDR_W-1:0]   w_phys;

  logic [8*LANES-1:0]   data_q;
  logic [8*LANES-1:0]   w_cpu_rword;
  logic [7:0]           vga_q_q;

  logic                 w_cpu_acc, w_cpu_wr, w_cpu_rd;
  logic [WADDR_W-1:0]   w_cpu_word, w_waddr, w_vword;
  logic [BW-1:0]        w_vbank;
  logic [7:0]           w_vbyte [LANES];

  // Clear engine: next-state and write strobe
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    fill_d   = fill_q;
    w_clr_wr = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (clr_start) begin
          fill_d  = clr_byte;
          ptr_d   = '0;
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        w_clr_wr = 1'b1;
        ptr_d    = ptr_q + 1'b1;
        if (ptr_d[WADDR_W]) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      fill_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      fill_q  <= fill_d;
    end
  end

  assign clr_busy  = (state_q != S_IDLE);
  assign clr_done  = (state_q == S_DONE);
  assign cpu_stall = clr_busy;

  assign w_cpu_acc  = ce & ~cpu_stall;
  assign w_cpu_wr   = w_cpu_acc & we;
  assign w_cpu_rd   = w_cpu_acc & ~we;
  assign w_cpu_word = addr[VADDR_W-1:LB];
  assign w_waddr    = w_clr_wr ? ptr_q[WADDR_W-1:0] : w_cpu_word;

  // A simultaneous load and vsync makes the new base live immediately
  always_comb begin
    pend_d = scroll_we ? scroll_i : pend_q;
    act_d  = vsync ? pend_d : act_q;
  end

  assign w_phys  = vga_rdaddress + act_q;
  assign w_vword = phys_q[VADDR_W-1:LB];

  generate
    if (LB > 0) begin : g_vbank_multi
      logic w_addr_unused;
      assign w_addr_unused = ^addr[BW-1:0];
      assign w_vbank       = phys_q[BW-1:0];
    end else begin : g_vbank_single
      assign w_vbank = '0;
    end
  endgenerate

  generate
    for (genvar i = 0; i < LANES; i++) begin : g_bank
      logic [7:0] mem [DEPTH];
      logic       w_lane_we;
      logic [7:0] w_lane_wd;

      assign w_lane_we = w_clr_wr | (w_cpu_wr & sel[i]);
      assign w_lane_wd = w_clr_wr ? fill_q : data_i[8*i +: 8];

      always_ff @(posedge clk) begin
        if (w_lane_we) mem[w_waddr] <= w_lane_wd;
      end

      assign w_cpu_rword[8*i +: 8] = mem[w_cpu_word];
      assign w_vbyte[i]            = mem[w_vword];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_q  <= '0;
      act_q   <= '0;
      phys_q  <= '0;
      vga_q_q <= '0;
      data_q  <= '0;
    end else begin
      pend_q  <= pend_d;
      act_q   <= act_d;
      phys_q  <= w_phys;
      vga_q_q <= w_vbyte[w_vbank];
      if (w_cpu_rd)      data_q <= w_cpu_rword;
      else if (w_cpu_wr) data_q <= '0;
    end
  end

  assign data_o = data_q;
  assign vga_q  = vga_q_q;

endmodule

`default_nettype wire

// File: doc/video_ram_mp.md
Name: video_ram_mp

Overview:
- Parametrised dual-port video memory. The CPU side offers word access with byte lanes; the VGA side offers byte-wide reads.
- Adds three functions over the current block:
  - a hardware clear-screen engine (FSM);
  - a hardware-scroll base offset, double-buffered and applied on vsync;
  - a CPU stall handshake.
- Sits between the memory-mapped CPU bus and the VGA character/pixel fetch logic.

Parameters:
- LANES, 4, bytes per CPU word (power of two, ≥1).
- WADDR_W, 10, CPU word-address width; depth = 2^WADDR_W words.
- VADDR_W, WADDR_W+log2(LANES), VGA byte-address width (derived; do not override).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- ce  in  1  CPU chip enable.
- we  in  1  CPU write enable (1 = write).
- addr  in  WADDR_W+log2(LANES)  CPU byte address; low log2(LANES) bits ignored.
- sel  in  LANES  byte-lane enables, bit i ↔ data_i[8i+7:8i].
- data_i  in  8*LANES  CPU write data.
- data_o  out  8*LANES  CPU read data.
- cpu_stall  out  1  CPU access not accepted this cycle.
- clr_start  in  1  one-cycle request to fill memory.
- clr_byte  in  8  fill byte, sampled with clr_start.
- clr_busy  out  1  clear engine running.
- clr_done  out  1  one-cycle pulse at clear completion.
- scroll_we  in  1  load pending scroll base.
- scroll_i  in  VADDR_W  new scroll base (bytes).
- vsync  in  1  frame-start pulse from VGA timing.
- vga_rdaddress  in  VADDR_W  logical VGA byte address.
- vga_q  out  8  VGA read byte.

Behaviour:
- Storage: LANES byte banks, each 2^WADDR_W deep. Byte address b maps to bank b mod LANES, word b / LANES.
- Reset (rst=0, async) sets:
  - outputs: data_o=0, vga_q=0, cpu_stall=0, clr_busy=0, clr_done=0;
  - internal state: FSM=IDLE, pending and active scroll=0.
  - Memory contents are not reset.
- CPU read (ce=1, we=0, not stalled):
  - data_o = word at addr, one cycle after the request;
  - data_o holds until the next accepted access.
- CPU write (ce=1, we=1, not stalled):
  - lanes with sel[i]=1 are written at the clock edge; sel=0 writes nothing;
  - data_o <= 0 on the following edge.
- ce=0: no memory access; data_o holds.
- cpu_stall = clr_busy, combinational.
  - A stalled access performs nothing and leaves data_o unchanged.
  - The CPU holds the request until the stall drops.
- Clear FSM: IDLE → CLEAR → DONE → IDLE.
  - IDLE: on clr_start=1, latch clr_byte, set ptr=0, go to CLEAR.
  - CLEAR: each cycle write {LANES{fill}} to all lanes of word ptr, then ptr++. After writing word 2^WADDR_W−1, go to DONE.
  - DONE: clr_done=1 for exactly one cycle, then IDLE.
  - clr_busy=1 in CLEAR and DONE.
  - clr_start outside IDLE is ignored.
  - Clear duration: 2^WADDR_W+1 cycles from the first CLEAR cycle to return to IDLE.
  - Reset mid-clear aborts: no clr_done, memory partially filled.
- Scroll:
  - scroll_we loads the pending register.
  - On vsync=1, active <= pending.
  - If scroll_we and vsync occur in the same cycle, scroll_i loads both registers.
- VGA read:
  - physical = (vga_rdaddress + active) mod 2^VADDR_W; the wrap is natural modulo.
  - Pipeline: edge 1 registers physical; edge 2 registers the RAM byte into vga_q.
  - Latency: address at cycle N → vga_q valid at cycle N+2. Throughput is one byte per cycle.
  - The VGA port is always enabled, independent of ce and clear state; during a clear it returns current (partially cleared) contents.
- Same-cycle write (CPU or clear) and VGA read of the same byte: the VGA port returns the old data (read-before-write).
- Width rules:
  - the scroll adder is VADDR_W wide with carry discarded;
  - ptr is WADDR_W+1 bits, where the MSB detects the end of the clear.

Test Plan:
- Reset, then CPU write addr=0x10, sel=4'b0101, data_i=0xAABBCCDD; read addr=0x10 → data_o=0x00BB00DD (prior content 0) one cycle after the read.
- clr_start with clr_byte=0x20, WADDR_W=4:
  - cpu_stall=clr_busy=1 for 17 cycles; clr_done pulses once;
  - a read at word 15 afterwards returns 0x20202020;
  - a CPU write attempted during the clear does not land.
- clr_start asserted again during the clear, and rst asserted mid-clear:
  - the second start is ignored;
  - the reset drops clr_busy immediately, with no clr_done and words ≥ ptr untouched.
- Scroll:
  - scroll_we with scroll_i=5 and no vsync: vga_rdaddress=0 returns byte 0.
  - After a vsync pulse, vga_rdaddress=0 returns byte 5, valid 2 cycles later.
  - scroll=2^VADDR_W−1 with vga_rdaddress=3 returns byte 2 (wrap).
- scroll_we and vsync in the same cycle with scroll_i=8 → active=8 in the next cycle.
- CPU write of byte 7 and VGA read of physical byte 7 in the same cycle → vga_q shows the old value; a read one cycle later shows the new value.
